// File: rtl/vending_pkg.sv
// Shared vending definitions: credit state encoding and default sizing of the coin accumulator.
package vending_pkg;

  localparam int unsigned DEF_WIDTH       = 5;
  localparam int unsigned DEF_MAX_AMOUNT  = 31;
  localparam int unsigned DEF_REFUND_UNIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_REFUND = 2'd2
  } state_e;

endpackage

// File: rtl/coin_accumulator_if.sv
// Coin/purchase/change bus between the vending front end (master) and the accumulator (slave).
interface coin_accumulator_if #(
  parameter int unsigned WIDTH = vending_pkg::DEF_WIDTH
);
  logic             coin_valid;
  logic [WIDTH-1:0] coin_value;
  logic             spend_valid;
  logic [WIDTH-1:0] spend_amount;
  logic             refund_req;
  logic             change_ready;
  logic [WIDTH-1:0] amount;
  logic             change_valid;
  logic [WIDTH-1:0] change_value;
  logic             coin_reject;
  logic             spend_ok;
  logic             spend_fail;
  logic             overflow;

  modport master (
    output coin_valid, coin_value, spend_valid, spend_amount, refund_req, change_ready,
    input  amount, change_valid, change_value, coin_reject, spend_ok, spend_fail, overflow
  );

  modport slave (
    input  coin_valid, coin_value, spend_valid, spend_amount, refund_req, change_ready,
    output amount, change_valid, change_value, coin_reject, spend_ok, spend_fail, overflow
  );
endinterface

// File: rtl/coin_accumulator_credit_checker.sv
// Combinational credit arithmetic: spend is judged on the current amount, the coin on the post-spend amount.
module credit_checker #(
  parameter int unsigned WIDTH      = vending_pkg::DEF_WIDTH,
  parameter int unsigned MAX_AMOUNT = vending_pkg::DEF_MAX_AMOUNT
) (
  input  logic [WIDTH-1:0] amount_i,
  input  logic [WIDTH-1:0] coin_value_i,
  input  logic [WIDTH-1:0] spend_amount_i,
  input  logic             spend_valid_i,
  input  logic             coin_valid_i,
  output logic             spend_fits_o,
  output logic             coin_fits_o,
  output logic [WIDTH:0]   post_coin_o
);
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_AMOUNT);
  localparam logic [WIDTH:0] ZERO_W = {(WIDTH+1){1'b0}};

  logic [WIDTH:0] amount_w_s;
  logic [WIDTH:0] spend_w_s;
  logic [WIDTH:0] coin_w_s;
  logic [WIDTH:0] post_spend_s;
  logic [WIDTH:0] coin_sum_s;

  // Widened sums so that a coin on top of a full purse is seen as too large instead of wrapping.
  always_comb begin
    amount_w_s   = {1'b0, amount_i};
    spend_w_s    = {1'b0, spend_amount_i};
    coin_w_s     = {1'b0, coin_value_i};
    spend_fits_o = (spend_w_s <= amount_w_s);
    if (spend_valid_i && spend_fits_o) begin
      post_spend_s = amount_w_s - spend_w_s;
    end else begin
      post_spend_s = amount_w_s;
    end
    coin_sum_s  = post_spend_s + coin_w_s;
    coin_fits_o = (coin_w_s != ZERO_W) && (coin_sum_s <= MAX_W);
    if (coin_valid_i && coin_fits_o) begin
      post_coin_o = coin_sum_s;
    end else begin
      post_coin_o = post_spend_s;
    end
  end
endmodule

// File: rtl/coin_accumulator.sv
// Vending credit accumulator: takes coins, deducts purchases and pays credit back in bounded change beats.
module coin_accumulator
  import vending_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned MAX_AMOUNT  = DEF_MAX_AMOUNT,
  parameter int unsigned REFUND_UNIT = DEF_REFUND_UNIT
) (
  input  logic               clk,
  input  logic               rst_n,
  coin_accumulator_if.slave  bus
);
  localparam logic [WIDTH-1:0] UNIT_W = WIDTH'(REFUND_UNIT);
  localparam logic [WIDTH-1:0] ZERO_N = {WIDTH{1'b0}};
  localparam logic [WIDTH:0]   ZERO_W = {(WIDTH+1){1'b0}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] amount_q, amount_d;
  logic             change_valid_q, change_valid_d;
  logic [WIDTH-1:0] change_value_q, change_value_d;
  logic             coin_reject_q, coin_reject_d;
  logic             spend_ok_q, spend_ok_d;
  logic             spend_fail_q, spend_fail_d;
  logic             overflow_q, overflow_d;

  logic             spend_fits_s;
  logic             coin_fits_s;
  logic [WIDTH:0]   post_coin_s;
  logic [WIDTH-1:0] remain_s;

  function automatic logic [WIDTH-1:0] beat_of(input logic [WIDTH-1:0] a);
    beat_of = (a < UNIT_W) ? a : UNIT_W;
  endfunction

  credit_checker #(
    .WIDTH      (WIDTH),
    .MAX_AMOUNT (MAX_AMOUNT)
  ) u_checker (
    .amount_i       (amount_q),
    .coin_value_i   (bus.coin_value),
    .spend_amount_i (bus.spend_amount),
    .spend_valid_i  (bus.spend_valid),
    .coin_valid_i   (bus.coin_valid),
    .spend_fits_o   (spend_fits_s),
    .coin_fits_o    (coin_fits_s),
    .post_coin_o    (post_coin_s)
  );

  // Next-state and next-output decode for the credit FSM.
  always_comb begin
    state_d        = state_q;
    amount_d       = amount_q;
    change_valid_d = change_valid_q;
    change_value_d = change_value_q;
    coin_reject_d  = 1'b0;
    spend_ok_d     = 1'b0;
    spend_fail_d   = 1'b0;
    overflow_d     = overflow_q;
    remain_s       = amount_q - change_value_q;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (bus.refund_req) begin
          coin_reject_d = bus.coin_valid;
          spend_fail_d  = bus.spend_valid;
          if (amount_q != ZERO_N) begin
            state_d        = ST_REFUND;
            change_valid_d = 1'b1;
            change_value_d = beat_of(amount_q);
          end else begin
            // Empty purse: refund is a pass-through back to IDLE, still clearing overflow.
            state_d    = ST_IDLE;
            overflow_d = 1'b0;
          end
        end else begin
          spend_ok_d     = bus.spend_valid & spend_fits_s;
          spend_fail_d   = bus.spend_valid & ~spend_fits_s;
          coin_reject_d  = bus.coin_valid & ~coin_fits_s;
          if (bus.coin_valid && !coin_fits_s && (bus.coin_value != ZERO_N)) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
          amount_d       = post_coin_s[WIDTH-1:0];
          state_d        = (post_coin_s == ZERO_W) ? ST_IDLE : ST_CREDIT;
          change_valid_d = 1'b0;
          change_value_d = ZERO_N;
        end
      end
      ST_REFUND: begin
        coin_reject_d = bus.coin_valid;
        spend_fail_d  = bus.spend_valid;
        if (change_valid_q && bus.change_ready) begin
          amount_d = remain_s;
          if (remain_s == ZERO_N) begin
            state_d        = ST_IDLE;
            change_valid_d = 1'b0;
            change_value_d = ZERO_N;
            overflow_d     = 1'b0;
          end else begin
            change_valid_d = 1'b1;
            change_value_d = beat_of(remain_s);
          end
        end else begin
          amount_d = amount_q;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        amount_d       = ZERO_N;
        change_valid_d = 1'b0;
        change_value_d = ZERO_N;
        overflow_d     = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      amount_q       <= {WIDTH{1'b0}};
      change_valid_q <= 1'b0;
      change_value_q <= {WIDTH{1'b0}};
      coin_reject_q  <= 1'b0;
      spend_ok_q     <= 1'b0;
      spend_fail_q   <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      amount_q       <= amount_d;
      change_valid_q <= change_valid_d;
      change_value_q <= change_value_d;
      coin_reject_q  <= coin_reject_d;
      spend_ok_q     <= spend_ok_d;
      spend_fail_q   <= spend_fail_d;
      overflow_q     <= overflow_d;
    end
  end

  assign bus.amount       = amount_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_value = change_value_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.spend_ok     = spend_ok_q;
  assign bus.spend_fail   = spend_fail_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator: hand-computed credit, refund and reset scenarios.
module tb_coin_accumulator;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  coin_accumulator_if #(.WIDTH(5)) bus ();

  coin_accumulator #(
    .WIDTH       (5),
    .MAX_AMOUNT  (31),
    .REFUND_UNIT (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.coin_valid   = 1'b0;
    bus.coin_value   = 5'd0;
    bus.spend_valid  = 1'b0;
    bus.spend_amount = 5'd0;
    bus.refund_req   = 1'b0;
    bus.change_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic coin(input logic [4:0] v);
    bus.coin_valid = 1'b1;
    bus.coin_value = v;
    tick();
  endtask

  task automatic spend(input logic [4:0] v);
    bus.spend_valid  = 1'b1;
    bus.spend_amount = v;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    #2;
    chk("rst_amount", 32'(bus.amount), 32'd0);
    chk("rst_cvalid", 32'(bus.change_valid), 32'd0);
    chk("rst_cvalue", 32'(bus.change_value), 32'd0);
    chk("rst_reject", 32'(bus.coin_reject), 32'd0);
    chk("rst_sok", 32'(bus.spend_ok), 32'd0);
    chk("rst_sfail", 32'(bus.spend_fail), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    bus.refund_req = 1'b1;
    tick();
    chk("idle_refund_cvalid", 32'(bus.change_valid), 32'd0);
    chk("idle_refund_amount", 32'(bus.amount), 32'd0);

    coin(5'd10);
    chk("coin1_amount", 32'(bus.amount), 32'd10);
    chk("coin1_reject", 32'(bus.coin_reject), 32'd0);
    coin(5'd10);
    chk("coin2_amount", 32'(bus.amount), 32'd20);
    coin(5'd10);
    chk("coin3_amount", 32'(bus.amount), 32'd30);
    chk("coin3_reject", 32'(bus.coin_reject), 32'd0);

    coin(5'd5);
    chk("ovf_reject", 32'(bus.coin_reject), 32'd1);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_amount", 32'(bus.amount), 32'd30);
    tick();
    chk("ovf_reject_pulse", 32'(bus.coin_reject), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    spend(5'd10);
    chk("spend10_amount", 32'(bus.amount), 32'd20);
    chk("spend10_ok", 32'(bus.spend_ok), 32'd1);

    bus.spend_valid  = 1'b1;
    bus.spend_amount = 5'd15;
    bus.coin_valid   = 1'b1;
    bus.coin_value   = 5'd10;
    tick();
    chk("same_ok", 32'(bus.spend_ok), 32'd1);
    chk("same_reject", 32'(bus.coin_reject), 32'd0);
    chk("same_amount", 32'(bus.amount), 32'd15);

    spend(5'd7);
    chk("spend7_amount", 32'(bus.amount), 32'd8);
    spend(5'd9);
    chk("spend9_fail", 32'(bus.spend_fail), 32'd1);
    chk("spend9_ok", 32'(bus.spend_ok), 32'd0);
    chk("spend9_amount", 32'(bus.amount), 32'd8);

    coin(5'd4);
    chk("coin4_amount", 32'(bus.amount), 32'd12);
    chk("coin4_sfail_pulse", 32'(bus.spend_fail), 32'd0);

    bus.refund_req = 1'b1;
    tick();
    chk("ref_cvalid", 32'(bus.change_valid), 32'd1);
    chk("ref_beat1", 32'(bus.change_value), 32'd5);
    chk("ref_amount", 32'(bus.amount), 32'd12);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_beat", 32'(bus.change_value), 32'd5);
      chk("stall_amount", 32'(bus.amount), 32'd12);
      chk("stall_cvalid", 32'(bus.change_valid), 32'd1);
    end
    bus.change_ready = 1'b1;
    tick();
    chk("beat1_amount", 32'(bus.amount), 32'd7);
    chk("beat2_value", 32'(bus.change_value), 32'd5);
    bus.change_ready = 1'b1;
    tick();
    chk("beat2_amount", 32'(bus.amount), 32'd2);
    chk("beat3_value", 32'(bus.change_value), 32'd2);
    bus.change_ready = 1'b1;
    tick();
    chk("done_amount", 32'(bus.amount), 32'd0);
    chk("done_cvalid", 32'(bus.change_valid), 32'd0);
    chk("done_ovf", 32'(bus.overflow), 32'd0);

    coin(5'd0);
    chk("zero_reject", 32'(bus.coin_reject), 32'd1);
    chk("zero_ovf", 32'(bus.overflow), 32'd0);
    coin(5'd31);
    chk("max_amount", 32'(bus.amount), 32'd31);
    chk("max_reject", 32'(bus.coin_reject), 32'd0);
    coin(5'd1);
    chk("full_reject", 32'(bus.coin_reject), 32'd1);
    chk("full_ovf", 32'(bus.overflow), 32'd1);
    chk("full_amount", 32'(bus.amount), 32'd31);
    spend(5'd31);
    chk("spend_all_ok", 32'(bus.spend_ok), 32'd1);
    chk("spend_all_amount", 32'(bus.amount), 32'd0);
    bus.refund_req = 1'b1;
    tick();
    chk("idle_refund_ovf", 32'(bus.overflow), 32'd0);
    chk("idle_refund_cv2", 32'(bus.change_valid), 32'd0);

    coin(5'd7);
    chk("coin7_amount", 32'(bus.amount), 32'd7);
    bus.refund_req   = 1'b1;
    bus.coin_valid   = 1'b1;
    bus.coin_value   = 5'd3;
    bus.spend_valid  = 1'b1;
    bus.spend_amount = 5'd2;
    tick();
    chk("prio_reject", 32'(bus.coin_reject), 32'd1);
    chk("prio_sfail", 32'(bus.spend_fail), 32'd1);
    chk("prio_ovf", 32'(bus.overflow), 32'd0);
    chk("prio_amount", 32'(bus.amount), 32'd7);
    chk("prio_cvalid", 32'(bus.change_valid), 32'd1);
    chk("prio_beat", 32'(bus.change_value), 32'd5);
    coin(5'd3);
    chk("refund_coin_reject", 32'(bus.coin_reject), 32'd1);
    chk("refund_coin_ovf", 32'(bus.overflow), 32'd0);
    chk("refund_coin_amount", 32'(bus.amount), 32'd7);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_amount", 32'(bus.amount), 32'd0);
    chk("midrst_cvalid", 32'(bus.change_valid), 32'd0);
    chk("midrst_cvalue", 32'(bus.change_value), 32'd0);
    bus.change_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_hold_cvalid", 32'(bus.change_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.change_ready = 1'b1;
    tick();
    chk("after_rst_cvalid", 32'(bus.change_valid), 32'd0);
    chk("after_rst_amount", 32'(bus.amount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
